// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
//   Request/response channel pair between a load/store initiator and the
//   dmem_responder data-memory block. Both channels use valid/ready handshakes.
//
//   Request channel  (initiator -> responder):
//     req_valid, req_write, req_addr[31:0], req_wdata[31:0], req_be[3:0]
//     req_ready (responder -> initiator)
//   Response channel (responder -> initiator):
//     resp_valid, resp_rdata[31:0], resp_err
//     resp_ready (initiator -> responder)
//
//   Modports: master = initiator (load/store unit), slave = responder.
// -----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Responder side of the core's data-memory interface. Accepts one load/store
//   at a time, waits WAIT_STATES cycles, performs the word access on internal
//   RAM and returns the result on the response channel.
//
//   Parameters:
//     DEPTH_WORDS  number of 32-bit RAM words (power of two)
//     WAIT_STATES  extra cycles between acceptance and access (0..15)
//     BASE_ADDR    byte address of word 0 (word aligned)
//
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   asynchronous active-high reset
//     bus    slave modport of dmem_responder_if (request + response channels)
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]   off_word;
    logic          addr_err;
    logic [AW-1:0] idx;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   merged;

    // Word offset from the base. BASE_ADDR is word aligned, so the byte
    // offset bits of (addr - base) equal addr[1:0] and are checked there.
    assign off_word = addr_q[31:2] - BASE_ADDR[31:2];
    assign addr_err = (addr_q[1:0] != 2'b00)
                   || (addr_q < BASE_ADDR)
                   || ({2'b00, off_word} >= 32'(DEPTH_WORDS));
    assign idx      = off_word[AW-1:0];

    // Byte-lane merge of the latched store data over the current word.
    always_comb begin
        merged = mem[idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_wdata = merged;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access edge: store commits here, before RESP is entered.
                    state_d = ST_RESP;
                    err_d   = addr_err;
                    if (addr_err || write_q) begin
                        rdata_d = '0;
                    end else begin
                        rdata_d = mem[idx];
                    end
                    mem_we = write_q && !addr_err;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents are deliberately not reset. mem_we derives from the
    // asynchronously reset state, so a reset before the access edge drops
    // the pending store.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= mem_wdata;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. dut uses default parameters; dut0 uses
//   WAIT_STATES=0, DEPTH_WORDS=16, BASE_ADDR=0x100 for the zero-wait and
//   base-offset boundaries.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    dmem_responder_if bus();
    dmem_responder_if bus0();

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .WAIT_STATES (2),
        .BASE_ADDR   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    dmem_responder #(
        .DEPTH_WORDS (16),
        .WAIT_STATES (0),
        .BASE_ADDR   (32'h0000_0100)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input bit sel, input logic v, input logic w,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] be);
        if (sel) begin
            bus0.req_valid = v; bus0.req_write = w; bus0.req_addr = a;
            bus0.req_wdata = wd; bus0.req_be = be;
        end else begin
            bus.req_valid = v; bus.req_write = w; bus.req_addr = a;
            bus.req_wdata = wd; bus.req_be = be;
        end
    endtask

    task automatic set_rr(input bit sel, input logic r);
        if (sel) bus0.resp_ready = r;
        else     bus.resp_ready  = r;
    endtask

    function automatic logic get_req_ready(input bit sel);
        return sel ? bus0.req_ready : bus.req_ready;
    endfunction

    function automatic logic get_resp_valid(input bit sel);
        return sel ? bus0.resp_valid : bus.resp_valid;
    endfunction

    function automatic logic [31:0] get_rdata(input bit sel);
        return sel ? bus0.resp_rdata : bus.resp_rdata;
    endfunction

    function automatic logic get_err(input bit sel);
        return sel ? bus0.resp_err : bus.resp_err;
    endfunction

    // One full transaction: accept, measure latency, check response, handshake.
    task automatic xact(input bit sel, input string tag, input logic w,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(get_req_ready(sel)), 32'd1);
        drive_req(sel, 1'b1, w, a, wd, be);
        @(posedge clk);
        #1;
        drive_req(sel, 1'b0, 1'b0, '0, '0, '0);
        lat = 0;
        while (!get_resp_valid(sel) && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, get_rdata(sel), exp_rd);
        check({tag, "_err"}, 32'(get_err(sel)), 32'(exp_err));
        set_rr(sel, 1'b1);
        @(posedge clk);
        #1;
        set_rr(sel, 1'b0);
        check({tag, "_ready_after"}, 32'(get_req_ready(sel)), 32'd1);
        check({tag, "_valid_after"}, 32'(get_resp_valid(sel)), 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_req(1'b1, 1'b0, 1'b0, '0, '0, '0);
        set_rr(1'b0, 1'b0);
        set_rr(1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready",  32'(bus.req_ready),  32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_rdata",      bus.resp_rdata,      32'h0);
        check("rst_err",        32'(bus.resp_err),   32'd0);

        // Full-word store and load
        xact(1'b0, "st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3, 32'h0, 1'b0);
        xact(1'b0, "ld10", 1'b0, 32'h10, 32'h0, 4'h0, 3, 32'hDEADBEEF, 1'b0);

        // Byte-lane store
        xact(1'b0, "stb0", 1'b1, 32'h10, 32'h000000AA, 4'b0001, 3, 32'h0, 1'b0);
        xact(1'b0, "ldb0", 1'b0, 32'h10, 32'h0, 4'hF, 3, 32'hDEADBEAA, 1'b0);

        // be=0 store is a legal no-op
        xact(1'b0, "stbe0", 1'b1, 32'h10, 32'h12345678, 4'b0000, 3, 32'h0, 1'b0);
        xact(1'b0, "ldbe0", 1'b0, 32'h10, 32'h0, 4'h0, 3, 32'hDEADBEAA, 1'b0);

        // Error cases; 0x1000/0x1002 would alias word 0 if range were ignored
        xact(1'b0, "st0",    1'b1, 32'h0,    32'h0BADF00D, 4'hF, 3, 32'h0, 1'b0);
        xact(1'b0, "ld13",   1'b0, 32'h13,   32'h0, 4'h0, 3, 32'h0, 1'b1);
        xact(1'b0, "ld1000", 1'b0, 32'h1000, 32'h0, 4'h0, 3, 32'h0, 1'b1);
        xact(1'b0, "st1000", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 3, 32'h0, 1'b1);
        xact(1'b0, "st1002", 1'b1, 32'h1002, 32'hFFFFFFFF, 4'hF, 3, 32'h0, 1'b1);
        xact(1'b0, "ld0",    1'b0, 32'h0,    32'h0, 4'h0, 3, 32'h0BADF00D, 1'b0);
        xact(1'b0, "stffc",  1'b1, 32'hFFC,  32'hCAFEF00D, 4'hF, 3, 32'h0, 1'b0);
        xact(1'b0, "ldffc",  1'b0, 32'hFFC,  32'h0, 4'h0, 3, 32'hCAFEF00D, 1'b0);

        // Response stall with a competing request held valid
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b1, 1'b1, 32'h10, 32'h55555555, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("stall_enter", 32'(bus.resp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 32'(bus.resp_valid), 32'd1);
            check("stall_rdata", bus.resp_rdata, 32'hDEADBEAA);
            check("stall_err",   32'(bus.resp_err), 32'd0);
            check("stall_rdy",   32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check("stall_rel_rdy",   32'(bus.req_ready),  32'd1);
        check("stall_rel_valid", 32'(bus.resp_valid), 32'd0);
        xact(1'b0, "ld10s", 1'b0, 32'h10, 32'h0, 4'h0, 3, 32'hDEADBEAA, 1'b0);

        // Reset during WAIT of a store
        xact(1'b0, "st20", 1'b1, 32'h20, 32'h11111111, 4'hF, 3, 32'h0, 1'b0);
        xact(1'b0, "ld20", 1'b0, 32'h20, 32'h0, 4'h0, 3, 32'h11111111, 1'b0);
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b1, 32'h20, 32'h22222222, 4'hF);
        @(posedge clk);
        #1;
        drive_req(1'b0, 1'b0, 1'b0, '0, '0, '0);
        check("rw_busy", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rw_req_ready",  32'(bus.req_ready),  32'd1);
        check("rw_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rw_rdata",      bus.resp_rdata,      32'h0);
        check("rw_err",        32'(bus.resp_err),   32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        xact(1'b0, "ld20r", 1'b0, 32'h20, 32'h0, 4'h0, 3, 32'h11111111, 1'b0);

        // Zero wait states, non-zero base, 16-word RAM
        xact(1'b1, "z_st13c", 1'b1, 32'h13C, 32'hA5A5A5A5, 4'hF, 1, 32'h0, 1'b0);
        xact(1'b1, "z_ld13c", 1'b0, 32'h13C, 32'h0, 4'h0, 1, 32'hA5A5A5A5, 1'b0);
        xact(1'b1, "z_ld140", 1'b0, 32'h140, 32'h0, 4'h0, 1, 32'h0, 1'b1);
        xact(1'b1, "z_ldfc",  1'b0, 32'hFC,  32'h0, 4'h0, 1, 32'h0, 1'b1);
        xact(1'b1, "z_st100", 1'b1, 32'h100, 32'h00C0FFEE, 4'b1100, 1, 32'h0, 1'b0);
        xact(1'b1, "z_st100b",1'b1, 32'h100, 32'h0000BEEF, 4'b0011, 1, 32'h0, 1'b0);
        xact(1'b1, "z_ld100", 1'b0, 32'h100, 32'h0, 4'h0, 1, 32'h00C0BEEF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
